score_keeper: RTL and testbench



---
 rtl/score_pkg.sv | 31 +++
 rtl/hit_pending_ctr.sv | 42 ++++
 rtl/score_keeper.sv | 172 +++++++++++++++++
 tb/tb_score_keeper.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and default constants for the score keeper and its pending-hit counters.
// Saturating add helper keeps the clamp arithmetic in one place.
package score_pkg;

  localparam int SCORE_W        = 12;
  localparam int DEF_MAX_SCORE  = 999;
  localparam int DEF_BUMPER_PTS = 10;
  localparam int DEF_TARGET_PTS = 25;
  localparam int DEF_SLING_PTS  = 5;
  localparam int DEF_BALLS      = 3;
  localparam int DEF_PEND_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    OVER  = 2'd3
  } state_t;

  // One extra bit of headroom so the clamp sees the true sum.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] b,
    input logic [SCORE_W-1:0] max_v
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/hit_pending_ctr.sv
// Saturating up/down count of hits waiting to be scored; updates one cycle after inc/dec.
// Increments at all-ones are dropped; a simultaneous inc and dec cancel.
module hit_pending_ctr
  import score_pkg::*;
#(
  parameter int W = DEF_PEND_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_nonzero,
  output logic o_full
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign o_nonzero = |cnt_q;
  assign o_full    = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !i_dec && !o_full) begin
      cnt_d = cnt_q + 1'b1;
    end else if (i_dec && !i_inc && o_nonzero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: queues hit pulses, applies one per cycle into a saturating accumulator,
// publishes the score only on animation strobes, and tracks balls, game-over and high score.
module score_keeper
  import score_pkg::*;
#(
  parameter int BUMPER_PTS = DEF_BUMPER_PTS,
  parameter int TARGET_PTS = DEF_TARGET_PTS,
  parameter int SLING_PTS  = DEF_SLING_PTS,
  parameter int MAX_SCORE  = DEF_MAX_SCORE,
  parameter int BALLS      = DEF_BALLS,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic               i_hit_bumper,
  input  logic               i_hit_target,
  input  logic               i_hit_sling,
  input  logic               i_ball_lost,
  input  logic               i_new_game,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_score_stb,
  output logic [SCORE_W-1:0] o_high_score,
  output logic [1:0]         o_balls_left,
  output logic               o_game_over
);

  localparam logic [SCORE_W-1:0] MAX_V    = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] BUMPER_V = SCORE_W'(BUMPER_PTS);
  localparam logic [SCORE_W-1:0] TARGET_V = SCORE_W'(TARGET_PTS);
  localparam logic [SCORE_W-1:0] SLING_V  = SCORE_W'(SLING_PTS);
  localparam logic [1:0]         BALLS_V  = 2'(BALLS);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               stb_q, stb_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [1:0]         balls_q, balls_d;
  logic               over_q, over_d;

  logic tgt_nz, bmp_nz, sl_nz;
  logic tgt_full, bmp_full, sl_full;
  logic tgt_dec, bmp_dec, sl_dec;
  logic in_play, apply_en, start;
  logic [SCORE_W-1:0] pts;

  assign in_play  = (state_q == PLAY);
  assign apply_en = (state_q == PLAY) || (state_q == DRAIN);
  assign start    = i_new_game && ((state_q == IDLE) || (state_q == OVER));

  hit_pending_ctr #(.W(PEND_W)) u_tgt_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (i_hit_target && in_play && !tgt_full),
    .i_dec     (tgt_dec),
    .i_clr     (start),
    .o_nonzero (tgt_nz),
    .o_full    (tgt_full)
  );

  hit_pending_ctr #(.W(PEND_W)) u_bmp_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (i_hit_bumper && in_play && !bmp_full),
    .i_dec     (bmp_dec),
    .i_clr     (start),
    .o_nonzero (bmp_nz),
    .o_full    (bmp_full)
  );

  hit_pending_ctr #(.W(PEND_W)) u_sl_ctr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_inc     (i_hit_sling && in_play && !sl_full),
    .i_dec     (sl_dec),
    .i_clr     (start),
    .o_nonzero (sl_nz),
    .o_full    (sl_full)
  );

  // One pending hit per cycle, target first, then bumper, then sling.
  always_comb begin
    tgt_dec = 1'b0;
    bmp_dec = 1'b0;
    sl_dec  = 1'b0;
    pts     = '0;
    if (apply_en) begin
      if (tgt_nz) begin
        tgt_dec = 1'b1;
        pts     = TARGET_V;
      end else if (bmp_nz) begin
        bmp_dec = 1'b1;
        pts     = BUMPER_V;
      end else if (sl_nz) begin
        sl_dec  = 1'b1;
        pts     = SLING_V;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = sat_add(acc_q, pts, MAX_V);
    balls_d = balls_q;
    high_d  = high_q;
    score_d = score_q;
    stb_d   = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (i_new_game) begin
          state_d = PLAY;
          acc_d   = '0;
          balls_d = BALLS_V;
        end
      end
      PLAY: begin
        if (i_ball_lost) begin
          balls_d = balls_q - 2'd1;
          if (balls_q <= 2'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!tgt_nz && !bmp_nz && !sl_nz) begin
          state_d = OVER;
          if (acc_q > high_q) begin
            high_d = acc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_ani_stb && i_animate && (acc_q != score_q)) begin
      score_d = acc_q;
      stb_d   = 1'b1;
    end

    over_d = (state_d == OVER);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      score_q <= '0;
      stb_q   <= 1'b0;
      high_q  <= '0;
      balls_q <= BALLS_V;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      stb_q   <= stb_d;
      high_q  <= high_d;
      balls_q <= balls_d;
      over_q  <= over_d;
    end
  end

  assign o_score      = score_q;
  assign o_score_stb  = stb_q;
  assign o_high_score = high_q;
  assign o_balls_left = balls_q;
  assign o_game_over  = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: expected published scores are queued when strobes are driven
// and popped whenever the DUT pulses o_score_stb.
module tb_score_keeper;

  localparam int MAX_S = 999;
  localparam int P_BMP = 10;
  localparam int P_TGT = 25;
  localparam int P_SL  = 5;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_animate;
  logic        i_hit_bumper, i_hit_target, i_hit_sling, i_ball_lost, i_new_game;
  logic [11:0] o_score, o_high_score;
  logic        o_score_stb, o_game_over;
  logic [1:0]  o_balls_left;

  always #5 i_clk = ~i_clk;

  score_keeper dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ani_stb    (i_ani_stb),
    .i_animate    (i_animate),
    .i_hit_bumper (i_hit_bumper),
    .i_hit_target (i_hit_target),
    .i_hit_sling  (i_hit_sling),
    .i_ball_lost  (i_ball_lost),
    .i_new_game   (i_new_game),
    .o_score      (o_score),
    .o_score_stb  (o_score_stb),
    .o_high_score (o_high_score),
    .o_balls_left (o_balls_left),
    .o_game_over  (o_game_over)
  );

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];
  int m_acc, m_pub, m_high, m_balls;
  bit m_play;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Every strobe pulse must match exactly one queued publish.
  always @(negedge i_clk) begin
    if (o_score_stb === 1'b1) begin
      if (sb_q.size() == 0) check("stb_without_publish", o_score_stb, 0);
      else check("published_score", o_score, sb_q.pop_front());
    end
  end

  function automatic int clamp_add(input int a, input int p);
    return (a + p > MAX_S) ? MAX_S : a + p;
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    m_acc = 0; m_pub = 0; m_high = 0; m_balls = 3; m_play = 0;
    sb_q.delete();
  endtask

  task automatic new_game();
    i_new_game = 1'b1;
    if (!m_play) begin
      m_play = 1; m_acc = 0; m_balls = 3;
    end
    cyc();
    i_new_game = 1'b0;
  endtask

  task automatic pulse(input bit b, input bit t, input bit s, input bit lost);
    i_hit_bumper = b; i_hit_target = t; i_hit_sling = s; i_ball_lost = lost;
    if (m_play) begin
      if (t) m_acc = clamp_add(m_acc, P_TGT);
      if (b) m_acc = clamp_add(m_acc, P_BMP);
      if (s) m_acc = clamp_add(m_acc, P_SL);
      if (lost) begin
        m_balls--;
        if (m_balls == 0) m_play = 0;
      end
    end
    cyc();
    i_hit_bumper = 0; i_hit_target = 0; i_hit_sling = 0; i_ball_lost = 0;
  endtask

  task automatic strobe(input bit animate, input int exp_acc);
    i_ani_stb = 1'b1;
    i_animate = animate;
    if (animate && exp_acc != m_pub) begin
      sb_q.push_back(exp_acc);
      m_pub = exp_acc;
    end
    cyc();
    i_ani_stb = 1'b0;
    i_animate = 1'b0;
  endtask

  task automatic settle(input string tag);
    cyc(2);
    check(tag, sb_q.size(), 0);
  endtask

  task automatic finish_game();
    if (m_acc > m_high) m_high = m_acc;
  endtask

  initial begin
    i_rst = 0; i_ani_stb = 0; i_animate = 0;
    i_hit_bumper = 0; i_hit_target = 0; i_hit_sling = 0; i_ball_lost = 0; i_new_game = 0;
    do_reset();
    check("rst_score", o_score, 0);
    check("rst_stb", o_score_stb, 0);
    check("rst_high", o_high_score, 0);
    check("rst_balls", o_balls_left, 3);
    check("rst_over", o_game_over, 0);

    // Single bumper hit published on one strobe.
    new_game();
    pulse(1, 0, 0, 0);
    cyc(3);
    strobe(1, m_acc);
    check("t1_score", o_score, 10);
    cyc();
    check("t1_stb_one_cycle", o_score_stb, 0);
    check("t1_balls", o_balls_left, 3);
    settle("t1_sb_empty");

    // Simultaneous hits: target is applied first, so an early strobe sees 25.
    do_reset();
    new_game();
    pulse(1, 1, 1, 0);
    cyc();
    strobe(1, P_TGT);
    cyc(3);
    strobe(1, m_acc);
    check("t2_score", o_score, 40);
    pulse(0, 0, 1, 0);
    cyc(3);
    strobe(0, m_acc);
    check("t2_no_animate_hold", o_score, 40);
    strobe(1, m_acc);
    check("t2_after_animate", o_score, 45);
    settle("t2_sb_empty");

    // Saturation at the three-digit ceiling.
    do_reset();
    new_game();
    repeat (39) begin
      pulse(0, 1, 0, 0);
      cyc();
    end
    cyc(2);
    strobe(1, m_acc);
    check("t3_below_clamp", o_score, 975);
    pulse(0, 1, 0, 0);
    cyc(3);
    strobe(1, m_acc);
    check("t3_clamped", o_score, 999);
    repeat (3) begin
      pulse(0, 1, 0, 0);
      cyc();
    end
    cyc(2);
    strobe(1, m_acc);
    strobe(1, m_acc);
    check("t3_hold", o_score, 999);
    settle("t3_sb_empty");

    // Full game to OVER, hits dropped in OVER, restart keeps the high score.
    do_reset();
    new_game();
    pulse(1, 1, 0, 0);
    cyc(3);
    strobe(1, m_acc);
    pulse(0, 0, 0, 1);
    check("t4_balls2", o_balls_left, 2);
    pulse(0, 0, 0, 1);
    check("t4_balls1", o_balls_left, 1);
    pulse(0, 0, 0, 1);
    cyc(4);
    finish_game();
    check("t4_over", o_game_over, 1);
    check("t4_high", o_high_score, m_high);
    check("t4_balls0", o_balls_left, 0);
    pulse(1, 1, 1, 0);
    cyc(3);
    strobe(1, m_acc);
    check("t4_over_hold", o_score, 35);
    new_game();
    check("t4_restart_balls", o_balls_left, 3);
    check("t4_restart_over", o_game_over, 0);
    check("t4_score_kept", o_score, 35);
    strobe(1, m_acc);
    check("t4_zero_published", o_score, 0);
    check("t4_high_kept", o_high_score, 35);
    settle("t4_sb_empty");

    // Last ball lost with a queued target and a fresh bumper: both scored before OVER.
    pulse(1, 0, 0, 0);
    cyc(3);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 1);
    cyc(5);
    finish_game();
    check("t5_over", o_game_over, 1);
    check("t5_high", o_high_score, m_high);
    strobe(1, m_acc);
    check("t5_score", o_score, 45);
    settle("t5_sb_empty");

    // Reset mid-game with pending hits.
    new_game();
    check("t6_over_clear", o_game_over, 0);
    repeat (3) pulse(1, 1, 1, 0);
    do_reset();
    check("t6_rst_score", o_score, 0);
    check("t6_rst_stb", o_score_stb, 0);
    check("t6_rst_high", o_high_score, 0);
    check("t6_rst_balls", o_balls_left, 3);
    check("t6_rst_over", o_game_over, 0);
    pulse(1, 1, 1, 0);
    cyc(3);
    strobe(1, m_acc);
    check("t6_idle_score", o_score, 0);
    new_game();
    cyc(6);
    strobe(1, m_acc);
    check("t6_pending_discarded", o_score, 0);
    settle("t6_sb_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
